// File: rtl/key_step_pulser_if.sv
// Pushbutton-side signal bundle for the step pulser: raw key in, Step/Pressed/StepCount out.
// The master drives the raw key and consumes the pulses; the slave is the conditioning block.
interface key_step_pulser_if #(
    parameter int COUNT_W = 16
);
    logic               KEY_n;
    logic               Step;
    logic               Pressed;
    logic [COUNT_W-1:0] StepCount;

    modport master (
        output KEY_n,
        input  Step,
        input  Pressed,
        input  StepCount
    );

    modport slave (
        input  KEY_n,
        output Step,
        output Pressed,
        output StepCount
    );
endinterface

// File: rtl/key_step_pulser.sv
// Debounces an active-low pushbutton into one Step pulse per press (auto-repeat with KEY_STEP_AUTOREPEAT_EN).
// Latency: Step high DEBOUNCE_CYCLES+2 edges after the key level first reaches the sync stage.
// No backpressure: Step is a fire-and-forget one-cycle pulse, never on consecutive cycles.
module key_step_pulser #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int COUNT_W         = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    key_step_pulser_if.slave key
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    state_t             state;
    logic               key_meta;
    logic               s_key;
    logic [DB_W-1:0]    db_cnt;
    logic               step;
    logic               pressed;
    logic [COUNT_W-1:0] step_count;

`ifdef KEY_STEP_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0]   rpt_cnt;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            key_meta   <= 1'b1;
            s_key      <= 1'b1;
            state      <= IDLE;
            db_cnt     <= '0;
            step       <= 1'b0;
            pressed    <= 1'b0;
            step_count <= '0;
`ifdef KEY_STEP_AUTOREPEAT_EN
            rpt_cnt    <= '0;
`endif
        end else begin
            key_meta <= key.KEY_n;
            s_key    <= key_meta;
            step     <= 1'b0;
`ifdef KEY_STEP_AUTOREPEAT_EN
            // Holding the repeat counter at zero outside HELD covers both exit and re-entry.
            if (state != HELD) begin
                rpt_cnt <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (!s_key) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (s_key) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state      <= HELD;
                        db_cnt     <= '0;
                        step       <= 1'b1;
                        pressed    <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                HELD: begin
                    if (s_key) begin
                        state  <= REL_WAIT;
                        db_cnt <= DB_ONE;
`ifdef KEY_STEP_AUTOREPEAT_EN
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == RPT_LAST) begin
                        rpt_cnt    <= '0;
                        step       <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
`endif
                    end
                end
                REL_WAIT: begin
                    // A pressed sample here is release bounce: fall back without a new Step.
                    if (!s_key) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= IDLE;
                        db_cnt  <= '0;
                        pressed <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

    assign key.Step      = step;
    assign key.Pressed   = pressed;
    assign key.StepCount = step_count;
endmodule

// File: tb/tb_key_step_pulser.sv
// Directed bench for key_step_pulser with a 16-bit and a 4-bit counter instance sharing one key.
module tb_key_step_pulser;
    localparam int DB = 4;
    localparam int RP = 8;

    logic Clock = 1'b0;
    logic Resetn;
    always #5 Clock = ~Clock;

    key_step_pulser_if #(.COUNT_W(16)) bus ();
    key_step_pulser_if #(.COUNT_W(4))  bus4 ();
    assign bus4.KEY_n = bus.KEY_n;

    key_step_pulser #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .COUNT_W(16)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .key   (bus)
    );

    key_step_pulser #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .COUNT_W(4)) dut4 (
        .Clock (Clock),
        .Resetn(Resetn),
        .key   (bus4)
    );

    typedef struct {
        string name;
        logic  key_n;
        int    cycles;
        int    exp_steps;
        int    exp_first;
        int    exp_pchg;
        logic  exp_pressed;
        int    exp_count;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs n edges, sampling 1 time unit after each rising edge.
    // first/pchg are 1-based edge indices (0 = never); pchg marks the first Pressed change.
    task automatic run_cycles(input int n, output int steps, output int first, output int pchg,
                              output int b2b, output int steps4);
        logic p0;
        logic prev;
        p0 = bus.Pressed;
        prev = 1'b0;
        steps = 0; first = 0; pchg = 0; b2b = 0; steps4 = 0;
        for (int j = 1; j <= n; j++) begin
            @(posedge Clock);
            #1;
            if (bus.Step === 1'b1) begin
                steps++;
                if (first == 0) first = j;
                if (prev) b2b++;
            end
            if (bus4.Step === 1'b1) steps4++;
            if (pchg == 0 && bus.Pressed !== p0) pchg = j;
            prev = bus.Step;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int steps, first, pchg, b2b, steps4;
        int tot, tot4;

        vecs[0]  = '{"idle",         1'b1, 10, 0, 0, 0, 1'b0, 0};
        vecs[1]  = '{"press",        1'b0, 30, 1, 6, 6, 1'b1, 1};
        vecs[2]  = '{"release",      1'b1, 30, 0, 0, 6, 1'b0, 1};
        vecs[3]  = '{"bounce0_a",    1'b0, 2,  0, 0, 0, 1'b0, 1};
        vecs[4]  = '{"bounce1_a",    1'b1, 2,  0, 0, 0, 1'b0, 1};
        vecs[5]  = '{"bounce0_b",    1'b0, 2,  0, 0, 0, 1'b0, 1};
        vecs[6]  = '{"bounce1_b",    1'b1, 2,  0, 0, 0, 1'b0, 1};
        vecs[7]  = '{"bounce0_c",    1'b0, 2,  0, 0, 0, 1'b0, 1};
        vecs[8]  = '{"bounce1_c",    1'b1, 2,  0, 0, 0, 1'b0, 1};
        vecs[9]  = '{"bounce_hold",  1'b0, 30, 1, 6, 6, 1'b1, 2};
        vecs[10] = '{"rel_bounce1",  1'b1, 2,  0, 0, 0, 1'b1, 2};
        vecs[11] = '{"rel_bounce0",  1'b0, 1,  0, 0, 0, 1'b1, 2};
        vecs[12] = '{"rel_settle",   1'b1, 20, 0, 0, 6, 1'b0, 2};

        bus.KEY_n = 1'b1;
        Resetn    = 1'b0;
        #1;
        check("reset_async_count", bus.StepCount, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            check("reset_step",    bus.Step,      0);
            check("reset_pressed", bus.Pressed,   0);
            check("reset_count",   bus.StepCount, 0);
        end
        Resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            bus.KEY_n = vecs[i].key_n;
            run_cycles(vecs[i].cycles, steps, first, pchg, b2b, steps4);
            check({vecs[i].name, "_steps"},   steps,         vecs[i].exp_steps);
            check({vecs[i].name, "_first"},   first,         vecs[i].exp_first);
            check({vecs[i].name, "_pchg"},    pchg,          vecs[i].exp_pchg);
            check({vecs[i].name, "_pressed"}, bus.Pressed,   vecs[i].exp_pressed);
            check({vecs[i].name, "_count"},   bus.StepCount, vecs[i].exp_count);
            check({vecs[i].name, "_b2b"},     b2b,           0);
        end

        // Reset two samples into PRESS_WAIT with the key still down.
        bus.KEY_n = 1'b0;
        run_cycles(4, steps, first, pchg, b2b, steps4);
        check("midrst_pre_steps", steps, 0);
        Resetn = 1'b0;
        #1;
        check("midrst_async_count", bus.StepCount, 0);
        check("midrst_async_step",  bus.Step,      0);
        run_cycles(2, steps, first, pchg, b2b, steps4);
        check("midrst_hold_steps", steps, 0);
        Resetn = 1'b1;
        run_cycles(20, steps, first, pchg, b2b, steps4);
        check("midrst_after_steps", steps,         1);
        check("midrst_after_first", first,         6);
        check("midrst_after_count", bus.StepCount, 1);
        check("midrst_after_pressed", bus.Pressed, 1);

        // Reset while HELD drops Pressed immediately.
        Resetn = 1'b0;
        #1;
        check("heldrst_async_pressed", bus.Pressed,   0);
        check("heldrst_async_count",   bus.StepCount, 0);
        bus.KEY_n = 1'b1;
        run_cycles(2, steps, first, pchg, b2b, steps4);
        Resetn = 1'b1;
        run_cycles(10, steps, first, pchg, b2b, steps4);
        check("heldrst_idle_steps", steps,         0);
        check("heldrst_idle_count", bus.StepCount, 0);

        // Seventeen clean presses: the 4-bit counter wraps through zero.
        tot = 0;
        tot4 = 0;
        for (int i = 0; i < 17; i++) begin
            bus.KEY_n = 1'b0;
            run_cycles(8, steps, first, pchg, b2b, steps4);
            tot += steps;
            tot4 += steps4;
            check("wrap_count4", bus4.StepCount, (i + 1) % 16);
            bus.KEY_n = 1'b1;
            run_cycles(8, steps, first, pchg, b2b, steps4);
            tot += steps;
            tot4 += steps4;
        end
        check("wrap_steps4",  tot4,          17);
        check("wrap_steps16", tot,           17);
        check("wrap_count16", bus.StepCount, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
